// File: rtl/acumulador_redondeo_pkg.sv
// rtl/acumulador_redondeo_pkg.sv - shared widths, saturation bounds and FSM states for the accumulate/round stage
package acumulador_redondeo_pkg;

    localparam int N     = 24;
    localparam int FRAC  = 16;
    localparam int TAPS  = 5;
    localparam int GUARD = 4;
    localparam int ACC_W = 2 * N + GUARD;

    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RND = 2'd1,
        ST_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/redondeo_saturacion.sv
// rtl/redondeo_saturacion.sv - round-half-up and saturate a guarded accumulator to the N-bit sample format
module redondeo_saturacion
    import acumulador_redondeo_pkg::*;
#(
    parameter int N_P     = N,
    parameter int FRAC_P  = FRAC,
    parameter int ACC_W_P = ACC_W
) (
    input  logic [ACC_W_P-1:0] acc_i,
    output logic [N_P-1:0]     y_o,
    output logic               sat_o
);

    localparam logic signed [ACC_W_P-1:0] HALF =
        {{(ACC_W_P-FRAC_P){1'b0}}, 1'b1, {(FRAC_P-1){1'b0}}};
    localparam logic signed [ACC_W_P-1:0] MAX_EXT =
        {{(ACC_W_P-N_P+1){1'b0}}, {(N_P-1){1'b1}}};
    localparam logic signed [ACC_W_P-1:0] MIN_EXT =
        {{(ACC_W_P-N_P+1){1'b1}}, {(N_P-1){1'b0}}};

    logic signed [ACC_W_P-1:0] biased;
    logic signed [ACC_W_P-1:0] r;

    // The guard bits leave headroom, so adding the half-LSB cannot wrap.
    assign biased = $signed(acc_i) + HALF;
    assign r      = biased >>> FRAC_P;

    always_comb begin
        y_o   = r[N_P-1:0];
        sat_o = 1'b0;
        if (r > MAX_EXT) begin
            y_o   = {1'b0, {(N_P-1){1'b1}}};
            sat_o = 1'b1;
        end else if (r < MIN_EXT) begin
            y_o   = {1'b1, {(N_P-1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/acumulador_redondeo.sv
// rtl/acumulador_redondeo.sv - sums TAPS signed products per sample, rounds/saturates and hands off via valid/ready
module acumulador_redondeo
    import acumulador_redondeo_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [2*N-1:0] prod_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sat
);

    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      y_q, y_d;
    logic              sat_q, sat_d;

    logic [N-1:0]      rs_y;
    logic              rs_sat;
    logic [ACC_W-1:0]  prod_ext;

    assign prod_ext = {{GUARD{prod_in[2*N-1]}}, prod_in};

    redondeo_saturacion u_rs (
        .acc_i (acc_q),
        .y_o   (rs_y),
        .sat_o (rs_sat)
    );

    // Handshake outputs depend only on state, never on in_valid/out_ready.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign y         = y_q;
    assign sat       = sat_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        sat_d   = sat_q;
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RND;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RND: begin
                y_d     = rs_y;
                sat_d   = rs_sat;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

endmodule
